// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-to-memory access path: default bus widths
// and the access sequencer's state encoding.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_SETUP,
    S_RD_STROBE,
    S_RD_WAIT,
    S_RD_ACK,
    S_DONE
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for flags driven from another timing
// domain (here: memory's strobe-edge logic).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences single-cycle CPU load/store requests into the main memory's
// strobe handshake, stalling the CPU until the access completes or times out.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int WR_PULSE = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic              cpuBusy,
  output logic              cpuDone,
  output logic [DATA_W-1:0] cpuRdata,
  output logic              cpuErr,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] memReadData,
  input  logic              memDataReady,
  output logic              dataGrabbed
);

  // One counter serves both the write pulse width and the read timeout.
  localparam int CNT_MAX = (TIMEOUT > WR_PULSE) ? TIMEOUT : WR_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rdy_sync;

  sync_2ff u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d_i (memDataReady),
    .q_o (rdy_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpuBusy     = 1'b1;
    cpuDone     = 1'b0;
    cpuErr      = 1'b0;
    memWrite    = 1'b0;
    memRead     = 1'b0;
    dataGrabbed = 1'b0;

    case (state_q)
      S_IDLE: begin
        cpuBusy = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        if (cpuReq) begin
          addr_d = cpuAddr;
          if (cpuWe) begin
            wdata_d = cpuWdata;
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD_SETUP;
          end
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        memWrite = 1'b1;
        if (cnt_q == WR_LAST) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        state_d = S_DONE;
      end
      S_RD_SETUP: begin
        // A ready flag left over from an earlier access must be cleared
        // before strobing, or it would be mistaken for this read's data.
        if (rdy_sync) begin
          dataGrabbed = 1'b1;
        end else begin
          state_d = S_RD_STROBE;
        end
      end
      S_RD_STROBE: begin
        memRead = 1'b1;
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        memRead = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (rdy_sync) begin
          rdata_d = memReadData;
          state_d = S_RD_ACK;
        end else if (cnt_q == RD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RD_ACK: begin
        dataGrabbed = 1'b1;
        if (!rdy_sync) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cpuDone = 1'b1;
        cpuErr  = err_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpuRdata     = rdata_q;
  assign memAddress   = addr_q;
  assign memWriteData = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a behavioural main
// memory and a word-array reference model of what each read must return.
module tb_mem_access_ctrl;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int WRP    = 2;
  localparam int TMO    = 64;
  localparam int WR_LAT = 1 + 1 + WRP + 1 + 1;  // accept cycle through DONE cycle

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpuReq = 1'b0;
  logic          cpuWe = 1'b0;
  logic [AW-1:0] cpuAddr = '0;
  logic [DW-1:0] cpuWdata = '0;
  logic          cpuBusy, cpuDone, cpuErr;
  logic [DW-1:0] cpuRdata;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData;
  logic          memWrite, memRead, dataGrabbed;
  logic [DW-1:0] memReadData = '0;
  logic          memDataReady = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WR_PULSE(WRP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuBusy(cpuBusy), .cpuDone(cpuDone), .cpuRdata(cpuRdata), .cpuErr(cpuErr),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead),
    .memReadData(memReadData), .memDataReady(memDataReady),
    .dataGrabbed(dataGrabbed)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural main memory: acts on strobe rising edges, 10-bit decode.
  logic [DW-1:0] mem [1024];
  logic          mw_p = 1'b0, mr_p = 1'b0, dg_p = 1'b0;
  logic          rd_pending = 1'b0;
  int            rd_cnt = 0;
  logic [9:0]    rd_addr = '0;
  int            mem_delay = 2;
  bit            no_respond = 1'b0;
  bit            stale_set = 1'b0;

  always @(posedge clk) begin
    mw_p <= memWrite;
    mr_p <= memRead;
    dg_p <= dataGrabbed;
    if (memWrite && !mw_p) mem[memAddress[9:0]] <= memWriteData;
    if (memRead && !mr_p) begin
      if (!no_respond) begin
        rd_pending <= 1'b1;
        rd_cnt     <= mem_delay;
        rd_addr    <= memAddress[9:0];
      end
    end else if (rd_pending) begin
      if (rd_cnt == 0) begin
        memReadData  <= mem[rd_addr];
        memDataReady <= 1'b1;
        rd_pending   <= 1'b0;
      end else begin
        rd_cnt <= rd_cnt - 1;
      end
    end
    if (dataGrabbed && !dg_p) memDataReady <= 1'b0;
    if (stale_set) begin
      memDataReady <= 1'b1;
      memReadData  <= 32'hBAD0_BAD0;
    end
  end

  // Reference model: word array indexed by the decoded address, plus the
  // values the registered DUT outputs are expected to hold.
  logic [DW-1:0] ref_mem [1024];
  logic [9:0]    wr_q [$];
  logic [DW-1:0] exp_rdata = '0;
  logic [AW-1:0] exp_maddr = '0;
  logic [DW-1:0] exp_wdata = '0;

  task automatic model_update(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic timed_out);
    exp_maddr = a;
    if (we) begin
      ref_mem[a[9:0]] = d;
      exp_wdata = d;
      wr_q.push_back(a[9:0]);
    end else if (!timed_out) begin
      exp_rdata = ref_mem[a[9:0]];
    end
  endtask

  // Drives one request and measures it; callers do their own comparisons.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output bit ok, output int lat, output logic err, output logic [DW-1:0] rdata,
                         output bit proto_bad, output logic [AW-1:0] maddr, output logic [DW-1:0] mwdata);
    int k;
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
    @(negedge clk);
    cpuReq = 1'b0; cpuWe = 1'($urandom_range(0, 1)); cpuAddr = $urandom; cpuWdata = $urandom;
    ok = 1'b0; proto_bad = 1'b0; k = 1;
    while (!ok && k < 400) begin
      if (cpuBusy !== 1'b1 || (memWrite && memRead)) proto_bad = 1'b1;
      if (cpuDone === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    lat = k + 1; err = cpuErr; rdata = cpuRdata; maddr = memAddress; mwdata = memWriteData;
    if (memRead !== 1'b0 || memWrite !== 1'b0 || dataGrabbed !== 1'b0) proto_bad = 1'b1;
    @(negedge clk);
    if (cpuBusy !== 1'b0 || cpuDone !== 1'b0 || cpuErr !== 1'b0) proto_bad = 1'b1;
    $display("txn we=%0b addr=%08h wdata=%08h -> done=%0b lat=%0d err=%0b rdata=%08h",
             we, addr, wdata, ok, lat, err, rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpuBusy, cpuDone, cpuErr, memWrite, memRead, dataGrabbed} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy/done/err/wr/rd/dg=%b, required 000000",
               {cpuBusy, cpuDone, cpuErr, memWrite, memRead, dataGrabbed});
    end
    checks++;
    if (cpuRdata !== '0 || memAddress !== '0 || memWriteData !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata=%08h maddr=%08h mwdata=%08h, required all 0",
               cpuRdata, memAddress, memWriteData);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    bit ok, pb; int lat; logic err; logic [DW-1:0] rd, mw; logic [AW-1:0] ma;
    run_txn(1'b1, 32'h005, 32'hDEAD_BEEF, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b1, 32'h005, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (!ok || pb) begin errors++; $display("FAIL wr_proto: done=%0b proto_bad=%0b, required 1/0", ok, pb); end
    checks++;
    if (lat != WR_LAT) begin errors++; $display("FAIL wr_latency: got %0d cycles, required %0d", lat, WR_LAT); end
    checks++;
    if (ma !== 32'h005 || mw !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_regs: maddr=%08h mwdata=%08h, required 00000005/deadbeef", ma, mw);
    end
    checks++;
    if (rd !== exp_rdata || err !== 1'b0) begin
      errors++; $display("FAIL wr_rdata_hold: rdata=%08h err=%0b, required %08h/0", rd, err, exp_rdata);
    end
    run_txn(1'b0, 32'h005, 32'h0, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b0, 32'h005, 32'h0, 1'b0);
    checks++;
    if (!ok || pb) begin errors++; $display("FAIL rd_proto: done=%0b proto_bad=%0b, required 1/0", ok, pb); end
    checks++;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++; $display("FAIL rd_data: rdata=%08h err=%0b, required deadbeef/0", rd, err);
    end
    checks++;
    if (mw !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_wdata_hold: mwdata=%08h, required deadbeef", mw); end
  endtask

  task automatic test_random();
    bit ok, pb; int lat; logic err, we; logic [DW-1:0] rd, mw, d; logic [AW-1:0] ma, a;
    for (int i = 0; i < 24; i++) begin
      mem_delay = $urandom_range(0, 8);
      we = (wr_q.size() == 0) || ($urandom_range(0, 1) == 1);
      d  = $urandom;
      if (we) a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1023));
      else    a = {22'($urandom), wr_q[$urandom_range(0, wr_q.size() - 1)]};
      run_txn(we, a, d, ok, lat, err, rd, pb, ma, mw);
      model_update(we, a, d, 1'b0);
      checks++;
      if (!ok || pb || err !== 1'b0) begin
        errors++; $display("FAIL rand_proto[%0d]: done=%0b proto_bad=%0b err=%0b, required 1/0/0", i, ok, pb, err);
      end
      checks++;
      if (rd !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %08h, required %08h", i, rd, exp_rdata); end
      checks++;
      if (ma !== exp_maddr || mw !== exp_wdata) begin
        errors++; $display("FAIL rand_regs[%0d]: maddr=%08h mwdata=%08h, required %08h/%08h", i, ma, mw, exp_maddr, exp_wdata);
      end
      if (we) begin
        checks++;
        if (lat != WR_LAT) begin errors++; $display("FAIL rand_wr_lat[%0d]: got %0d, required %0d", i, lat, WR_LAT); end
      end
    end
    mem_delay = 2;
  endtask

  task automatic test_timeout();
    bit ok, pb; int lat; logic err; logic [DW-1:0] rd, mw; logic [AW-1:0] ma;
    no_respond = 1'b1;
    run_txn(1'b0, 32'h005, 32'h0, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b0, 32'h005, 32'h0, 1'b1);
    no_respond = 1'b0;
    checks++;
    if (!ok || pb) begin errors++; $display("FAIL tmo_proto: done=%0b proto_bad=%0b, required 1/0", ok, pb); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: err=%0b with done, required 1", err); end
    checks++;
    if (rd !== exp_rdata) begin errors++; $display("FAIL tmo_rdata: got %08h, required unchanged %08h", rd, exp_rdata); end
    checks++;
    if (lat <= TMO || lat > TMO + 8) begin
      errors++; $display("FAIL tmo_latency: got %0d cycles, required %0d..%0d", lat, TMO + 1, TMO + 8);
    end
  endtask

  task automatic test_stale();
    bit done, seen_dg, dg_before, rd_seen; logic rdy_at_rd, err; logic [DW-1:0] rd; int k;
    @(negedge clk); stale_set = 1'b1;
    @(negedge clk); stale_set = 1'b0;
    repeat (3) @(negedge clk);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h005;
    @(negedge clk); cpuReq = 1'b0;
    done = 1'b0; seen_dg = 1'b0; dg_before = 1'b0; rd_seen = 1'b0; rdy_at_rd = 1'b1; k = 0;
    while (!done && k < 200) begin
      if (dataGrabbed && !rd_seen) seen_dg = 1'b1;
      if (memRead && !rd_seen) begin rd_seen = 1'b1; dg_before = seen_dg; rdy_at_rd = memDataReady; end
      if (cpuDone) done = 1'b1;
      else begin @(negedge clk); k++; end
    end
    rd = cpuRdata; err = cpuErr;
    @(negedge clk);
    model_update(1'b0, 32'h005, 32'h0, 1'b0);
    $display("txn stale read addr=00000005 -> done=%0b dg_first=%0b rdata=%08h", done, dg_before, rd);
    checks++;
    if (!done || !dg_before || rdy_at_rd !== 1'b0) begin
      errors++; $display("FAIL stale_ack: done=%0b grabbed_before_read=%0b ready_at_strobe=%0b, required 1/1/0",
                         done, dg_before, rdy_at_rd);
    end
    checks++;
    if (rd !== exp_rdata || err !== 1'b0) begin
      errors++; $display("FAIL stale_data: rdata=%08h err=%0b, required %08h/0", rd, err, exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, pb, bad; int lat, k; logic err; logic [DW-1:0] rd, mw; logic [AW-1:0] ma;
    run_txn(1'b1, 32'h3FF, 32'hCAFE_F00D, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b1, 32'h3FF, 32'hCAFE_F00D, 1'b0);
    mem_delay = 20;
    @(negedge clk); cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h3FF;
    @(negedge clk); cpuReq = 1'b0;
    k = 0;
    while (!memRead && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (memRead !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: memRead=%0b before reset, required 1", memRead); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpuBusy, cpuDone, cpuErr, memWrite, memRead, dataGrabbed} !== 6'b0 ||
        cpuRdata !== '0 || memAddress !== '0 || memWriteData !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: ctl=%b rdata=%08h maddr=%08h, required all 0",
                         {cpuBusy, cpuDone, cpuErr, memWrite, memRead, dataGrabbed}, cpuRdata, memAddress);
    end
    rst = 1'b0;
    exp_rdata = '0; exp_maddr = '0; exp_wdata = '0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (cpuDone !== 1'b0 || cpuBusy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_mid_quiet: done/busy seen after reset, required none"); end
    mem_delay = 3;
    run_txn(1'b0, 32'h3FF, 32'h0, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b0, 32'h3FF, 32'h0, 1'b0);
    checks++;
    if (!ok || pb || rd !== 32'hCAFE_F00D || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_reread: done=%0b proto_bad=%0b rdata=%08h err=%0b, required 1/0/cafef00d/0",
                         ok, pb, rd, err);
    end
    mem_delay = 2;
  endtask

  task automatic test_back_to_back();
    logic          op_we   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] op_addr [6] = '{32'h001, 32'h002, 32'h001, 32'h002, 32'h001, 32'h001};
    logic [DW-1:0] op_data [6];
    int idx, gap, k; bit after_done, overlap;
    for (int i = 0; i < 6; i++) op_data[i] = $urandom;
    mem_delay = $urandom_range(0, 4);
    @(negedge clk);
    idx = 0; gap = 0; k = 0; after_done = 1'b0; overlap = 1'b0;
    cpuReq = 1'b1; cpuWe = op_we[0]; cpuAddr = op_addr[0]; cpuWdata = op_data[0];
    while (idx < 6 && k < 2000) begin
      @(negedge clk); k++;
      if (memWrite && memRead) overlap = 1'b1;
      if (cpuDone) begin
        model_update(op_we[idx], op_addr[idx], op_data[idx], 1'b0);
        $display("txn b2b[%0d] we=%0b addr=%08h -> rdata=%08h maddr=%08h", idx, op_we[idx], op_addr[idx], cpuRdata, memAddress);
        checks++;
        if (cpuRdata !== exp_rdata || memAddress !== exp_maddr || cpuErr !== 1'b0) begin
          errors++; $display("FAIL b2b_txn[%0d]: rdata=%08h maddr=%08h err=%0b, required %08h/%08h/0",
                             idx, cpuRdata, memAddress, cpuErr, exp_rdata, exp_maddr);
        end
        idx++;
        if (idx < 6) begin cpuWe = op_we[idx]; cpuAddr = op_addr[idx]; cpuWdata = op_data[idx]; end
        else cpuReq = 1'b0;
        after_done = 1'b1; gap = 0;
      end else if (!cpuBusy) begin
        gap++;
      end else if (after_done) begin
        checks++;
        if (gap != 1) begin errors++; $display("FAIL b2b_gap[%0d]: busy low for %0d cycles, required 1", idx, gap); end
        after_done = 1'b0;
      end
    end
    cpuReq = 1'b0;
    checks++;
    if (idx != 6 || overlap) begin
      errors++; $display("FAIL b2b_complete: completed=%0d overlap=%0b, required 6/0", idx, overlap);
    end
    @(negedge clk);
    mem_delay = 2;
  endtask

  task automatic test_wrap();
    bit ok, pb; int lat; logic err; logic [DW-1:0] rd, mw; logic [AW-1:0] ma;
    run_txn(1'b1, 32'h0000_0400, 32'h1234_5678, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0);
    checks++;
    if (!ok || pb || ma !== 32'h0000_0400 || lat != WR_LAT) begin
      errors++; $display("FAIL wrap_write: done=%0b proto_bad=%0b maddr=%08h lat=%0d, required 1/0/00000400/%0d",
                         ok, pb, ma, lat, WR_LAT);
    end
    run_txn(1'b0, 32'h0000_0000, 32'h0, ok, lat, err, rd, pb, ma, mw);
    model_update(1'b0, 32'h0000_0000, 32'h0, 1'b0);
    checks++;
    if (!ok || pb || rd !== 32'h1234_5678 || err !== 1'b0) begin
      errors++; $display("FAIL wrap_read: done=%0b proto_bad=%0b rdata=%08h err=%0b, required 1/0/12345678/0",
                         ok, pb, rd, err);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_random();
    test_timeout();
    test_stale();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer between the CPU load/store stage and the main memory block.
- Converts a single-cycle CPU request into the memory's strobe handshake:
  - write: address/data setup, then a writeMem pulse;
  - read: readMem strobe, wait for memDataReady, capture data, then the dataGrabbed acknowledge.
- Stalls the CPU (cpuBusy) for the whole transaction and reports a timeout error if memory never answers.

Parameters:
- ADDR_W, 32, width of word address passed to memory (memory decodes low 10 bits)
- DATA_W, 32, data width
- WR_PULSE, 2, cycles memWrite is held high (min 1)
- TIMEOUT, 64, max cycles waiting for memDataReady before abort (min 4)

Ports:
- clk  in  1  system clock, all logic posedge
- rst  in  1  synchronous active-high reset
- cpuReq  in  1  request, sampled only in IDLE
- cpuWe  in  1  1=write, 0=read; sampled with cpuReq
- cpuAddr  in  ADDR_W  word address
- cpuWdata  in  DATA_W  write data
- cpuBusy  out  1  high from cycle after accept until DONE inclusive
- cpuDone  out  1  one-cycle completion pulse
- cpuRdata  out  DATA_W  read result, valid with cpuDone, held until next read completes
- cpuErr  out  1  one-cycle pulse with cpuDone on timeout
- memAddress  out  ADDR_W  registered address to memory
- memWriteData  out  DATA_W  registered write data
- memWrite  out  1  write strobe (memory acts on rising edge)
- memRead  out  1  read strobe (memory acts on rising edge)
- memReadData  in  DATA_W  memory output data
- memDataReady  in  1  memory data-valid flag
- dataGrabbed  out  1  acknowledge to memory; memory clears memDataReady on its rising edge

Behaviour:
- Reset: state IDLE; all outputs 0; cpuRdata 0; timeout counter 0. Reset mid-transaction aborts immediately with no cpuDone, and drops memRead/memWrite/dataGrabbed in the same cycle.
- memDataReady passes through a 2-flop synchronizer (rdySync) before use, since memory drives it from its own strobe edges.
- IDLE:
  - on cpuReq, latch cpuAddr into memAddress and cpuWdata into memWriteData (write only), set cpuBusy.
  - cpuWe=1 goes to WR_SETUP; cpuWe=0 goes to RD_SETUP.
- WR_SETUP: 1 cycle, address/data stable, strobes low. Goes to WR_PULSE.
- WR_PULSE: memWrite=1 for WR_PULSE cycles, then WR_HOLD.
- WR_HOLD: memWrite=0 with address/data held 1 cycle (hold time). Goes to DONE.
- RD_SETUP: 1 cycle. If rdySync is already 1 (stale flag), assert dataGrabbed and stay until rdySync=0, then deassert dataGrabbed. Next state is RD_STROBE.
- RD_STROBE: memRead=1, clear counter, go to RD_WAIT.
- RD_WAIT: memRead held high; counter increments.
  - On rdySync=1: capture memReadData into cpuRdata, go to RD_ACK.
  - If counter reaches TIMEOUT-1 with no ready: set err flag, drop memRead, go to DONE.
- RD_ACK: dataGrabbed=1 and memRead=0 until rdySync=0, then dataGrabbed=0, go to DONE.
  - No timeout in this state; memory clears on the acknowledge edge.
- DONE:
  - cpuDone=1 for 1 cycle; cpuErr=err flag; cpuBusy=1 this cycle.
  - Next cycle: IDLE, cpuBusy=0, err cleared.
  - A cpuReq asserted during DONE is ignored; it is accepted the first IDLE cycle it is still high.
- Latency from accept to cpuDone:
  - write: 1+1+WR_PULSE+1+1 = 6 cycles at defaults;
  - read: 2 cycles + synchronizer delay (2) + memory response + ack round trip.
- At most one transaction outstanding.
- cpuReq/cpuWe/cpuAddr/cpuWdata are ignored outside IDLE.
- memAddress and memWriteData change only on accept; they hold their values after completion.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_STROBE, RD_WAIT, RD_ACK, DONE) and default ADDR_W/DATA_W constants. main memory reuses the width constants.
- One sub-module: sync_2ff (parameterless 1-bit 2-flop synchronizer), reused elsewhere.

Test Plan:
- Write, then read back: write cpuAddr=0x005, data 0xDEADBEEF; read 0x005 -> cpuRdata=0xDEADBEEF with cpuErr=0. The write pulses cpuDone exactly 6 cycles after accept.
- Memory never raises ready on a read (TIMEOUT=64) -> cpuDone and cpuErr high together; memRead low; cpuRdata unchanged from the prior value.
- Stale memDataReady=1 at read accept -> dataGrabbed pulses and clears it before memRead rises; the returned data comes from the new read.
- Reset pulse in RD_WAIT -> next cycle all outputs 0 and state IDLE; no cpuDone. A subsequent read to 0x3FF completes normally.
- cpuReq held high continuously with alternating addresses 0x001/0x002 -> requests are accepted only in IDLE; cpuBusy drops for exactly 1 cycle between transactions; there are no overlapping strobes.
- Address wrap: write 0x12345678 at cpuAddr=0x00000400 -> memAddress=0x00000400 driven unchanged. A read of 0x000 returns 0x12345678, because memory decodes only the low 10 bits.
